// File: rtl/morse_key_receiver.sv
// -----------------------------------------------------------------------------
// morse_key_receiver
//
// Decodes a hand-keyed Morse signal into letters. The key level is
// synchronised, press and gap durations are measured in clk cycles, each press
// is classified as glitch / dot / dash, and a letter is completed once the key
// has stayed released for three time units.
//
// Parameters
//   UNIT_CYCLES    clk cycles per Morse time unit
//   GLITCH_CYCLES  presses shorter than this are treated as noise
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   key_in      raw key level (1 = pressed), asynchronous to clk
//   clear       synchronous discard of the letter in progress
//   code[4:0]   last completed letter, bit i = symbol i (1 = dash, 0 = dot)
//   len[2:0]    number of symbols in code (0 after reset)
//   code_valid  one-cycle pulse when code/len update
//   err         one-cycle pulse when a letter is dropped for having > 5 symbols
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module morse_key_receiver #(
  parameter int unsigned UNIT_CYCLES   = 5_000_000,
  parameter int unsigned GLITCH_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       clear,
  output logic [4:0] code,
  output logic [2:0] len,
  output logic       code_valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    OVF   = 2'd3
  } state_t;

  // Thresholds are kept one bit wider than the counter so that "counter + 2"
  // never wraps, even when the counter is saturated.
  localparam logic [32:0] GLITCH_LIM = 33'(GLITCH_CYCLES);
  localparam logic [32:0] DASH_LIM   = 33'(UNIT_CYCLES) << 1;
  localparam logic [32:0] GAP_LIM    = 33'(UNIT_CYCLES) * 33'd3;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic        sync1_q, sync1_d;
  logic        ks_q, ks_d;
  logic        ks_prev_q, ks_prev_d;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  sym_buf_q, sym_buf_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic [4:0]  code_q, code_d;
  logic [2:0]  len_q, len_d;
  logic        code_valid_q, code_valid_d;
  logic        err_q, err_d;

  // ---------------------------------------------------------------------------
  // Derived timing terms
  // ---------------------------------------------------------------------------
  logic        key_rise;
  logic        gap_done;
  logic        press_glitch;
  logic        press_dash;
  logic [31:0] cnt_sat;
  logic [32:0] press_dur;
  logic [32:0] low_run;

  // A rising edge only counts once the key has been seen released after
  // reset, so a key held through reset is ignored until pressed again.
  assign key_rise = ks_q & ~ks_prev_q & armed_q;

  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

  // The counter is cleared on state entry, one cycle after the edge that
  // caused the entry; the cycle containing that edge is therefore added back.
  //   PRESS, at the falling edge : high cycles = cnt + 1
  //   GAP/OVF, while low         : low cycles including this one = cnt + 2
  assign press_dur = {1'b0, cnt_q} + 33'd1;
  assign low_run   = {1'b0, cnt_q} + 33'd2;

  assign press_glitch = (press_dur < GLITCH_LIM);
  assign press_dash   = (press_dur >= DASH_LIM);

  // The falling-edge cycle itself never completes a gap, which keeps the
  // low-run arithmetic above valid in OVF after a press.
  assign gap_done = ~ks_q & ~ks_prev_q & (low_run >= GAP_LIM);

  // ---------------------------------------------------------------------------
  // Synchroniser and arming
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d   = key_in;
    ks_d      = sync1_q;
    ks_prev_d = ks_q;
    // fill_q[1] is set once ks_q carries a key_in sample taken after reset.
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & ~ks_q);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (key_rise) state_d = PRESS;
      end
      PRESS: begin
        if (!ks_q) begin
          if (press_glitch) begin
            state_d = (sym_cnt_q != 3'd0) ? GAP : IDLE;
          end else if (sym_cnt_q == 3'd5) begin
            state_d = OVF;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (key_rise) begin
          state_d = PRESS;
        end else if (gap_done) begin
          state_d = IDLE;
        end
      end
      OVF: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // ---------------------------------------------------------------------------
  // FSM: output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d        = cnt_q;
    sym_buf_d    = sym_buf_q;
    sym_cnt_d    = sym_cnt_q;
    code_d       = code_q;
    len_d        = len_q;
    code_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      PRESS: begin
        if (ks_q) begin
          cnt_d = cnt_sat;
        end else if (!press_glitch && (sym_cnt_q != 3'd5)) begin
          for (int i = 0; i < 5; i++) begin
            if (sym_cnt_q == 3'(i)) sym_buf_d[i] = press_dash;
          end
          sym_cnt_d = sym_cnt_q + 3'd1;
        end
      end
      GAP: begin
        if (!ks_q) cnt_d = cnt_sat;
        if (gap_done) begin
          code_d       = sym_buf_q;
          len_d        = sym_cnt_q;
          code_valid_d = 1'b1;
        end
      end
      OVF: begin
        // Presses are ignored; each new press restarts the gap measurement
        // and the count is held until the key has been low for two cycles.
        if (ks_q && !ks_prev_q) begin
          cnt_d = '0;
        end else if (!ks_q && !ks_prev_q) begin
          cnt_d = cnt_sat;
        end
        if (gap_done) err_d = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Returning to idle always empties the letter in progress.
    if (state_d == IDLE) begin
      sym_buf_d = '0;
      sym_cnt_d = '0;
    end

    if (clear) begin
      code_d       = code_q;
      len_d        = len_q;
      code_valid_d = 1'b0;
      err_d        = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      ks_q         <= 1'b0;
      ks_prev_q    <= 1'b0;
      fill_q       <= 2'b00;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      sym_buf_q    <= '0;
      sym_cnt_q    <= '0;
      code_q       <= '0;
      len_q        <= '0;
      code_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      ks_q         <= ks_d;
      ks_prev_q    <= ks_prev_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      sym_buf_q    <= sym_buf_d;
      sym_cnt_q    <= sym_cnt_d;
      code_q       <= code_d;
      len_q        <= len_d;
      code_valid_q <= code_valid_d;
      err_q        <= err_d;
    end
  end

  assign code       = code_q;
  assign len        = len_q;
  assign code_valid = code_valid_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_receiver.sv
// -----------------------------------------------------------------------------
// tb_morse_key_receiver
//
// Drives key press / release sequences (directed and $urandom) into
// morse_key_receiver with UNIT_CYCLES=10, GLITCH_CYCLES=3. A reference model
// works on whole press and gap durations: it classifies each press, collects a
// letter, and predicts each code_valid / err event including the clock cycle
// on which it must appear. A monitor records the events the DUT produces.
// -----------------------------------------------------------------------------
module tb_morse_key_receiver;

  localparam int UNIT   = 10;
  localparam int GLITCH = 3;
  // Release sampled at posedge c+1 reaches ks at c+2; the letter completes
  // after 3*UNIT low cycles on ks.
  localparam int EVT_LAT = 2 + 3 * UNIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       clear;
  logic [4:0] code;
  logic [2:0] len;
  logic       code_valid;
  logic       err;
  logic       busy;

  morse_key_receiver #(
    .UNIT_CYCLES  (UNIT),
    .GLITCH_CYCLES(GLITCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .clear     (clear),
    .code      (code),
    .len       (len),
    .code_valid(code_valid),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [4:0] code;
    logic [2:0] len;
  } evt_t;

  evt_t obs[$];
  evt_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   both_hi = 0;

  // Event monitor, sampling on the falling edge.
  always @(negedge clk) begin
    evt_t e;
    if (rst === 1'b0) begin
      if (code_valid === 1'b1 || err === 1'b1) begin
        e.cyc    = cyc;
        e.is_err = (err === 1'b1);
        e.code   = code;
        e.len    = len;
        obs.push_back(e);
      end
      if (code_valid === 1'b1 && err === 1'b1) both_hi++;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: whole-duration view of the keying rules
  // ---------------------------------------------------------------------------
  bit         m_sym[$];
  bit         m_ovf  = 1'b0;
  logic [4:0] m_code = '0;
  logic [2:0] m_len  = '0;

  task automatic model_press(input int h);
    if (!m_ovf && h >= GLITCH) begin
      if (m_sym.size() == 5) m_ovf = 1'b1;
      else m_sym.push_back(h >= 2 * UNIT);
    end
  endtask

  task automatic model_low(input int l, input int c);
    evt_t e;
    if (l >= 3 * UNIT) begin
      if (m_ovf) begin
        e.cyc = c + EVT_LAT; e.is_err = 1'b1; e.code = m_code; e.len = m_len;
        exp_q.push_back(e);
      end else if (m_sym.size() > 0) begin
        m_code = '0;
        foreach (m_sym[i]) m_code[i] = m_sym[i];
        m_len = 3'(m_sym.size());
        e.cyc = c + EVT_LAT; e.is_err = 1'b0; e.code = m_code; e.len = m_len;
        exp_q.push_back(e);
      end
      m_sym.delete();
      m_ovf = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus: list of (press, low) durations, applied from a falling edge
  // ---------------------------------------------------------------------------
  int seq_h[$];
  int seq_l[$];

  task automatic add(input int h, input int l);
    seq_h.push_back(h);
    seq_l.push_back(l);
  endtask

  task automatic run_seq();
    int c;
    foreach (seq_h[i]) begin
      key_in = 1'b1;
      repeat (seq_h[i]) @(negedge clk);
      model_press(seq_h[i]);
      c = cyc;
      key_in = 1'b0;
      repeat (seq_l[i]) @(negedge clk);
      model_low(seq_l[i], c);
    end
    seq_h.delete();
    seq_l.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; key_in = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({code, len, code_valid, err, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got code=%b len=%0d cv=%b err=%b busy=%b, expected all 0",
               code, len, code_valid, err, busy);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || len !== 3'd0 || code !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b code=%b len=%0d, expected 0/0/0", busy, code, len);
    end
    $display("reset: code=%b len=%0d busy=%b", code, len, busy);
  endtask

  task automatic test_letters();
    int n;
    obs.delete(); exp_q.delete();
    @(negedge clk);
    // "A", dot/dash boundary, glitch mid-letter, glitch boundary, gap boundary
    add(10, 10); add(30, 40);
    add(19, 40);
    add(20, 40);
    add(10, 5); add(2, 40);
    add(2, 40);
    add(3, 40);
    add(10, 29); add(10, 40);
    add(10, 30); add(10, 40);
    add(25, 10); add(25, 10); add(25, 10); add(25, 10); add(10, 40);
    // Six dots: overflow, code/len keep their prior value
    for (int i = 0; i < 5; i++) add(10, 10);
    add(10, 40);
    // Overflow with further presses and a glitch while overflowed
    for (int i = 0; i < 7; i++) add(10, 10);
    add(2, 5); add(10, 40);
    run_seq();
    // Random letters
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 7);
      for (int p = 0; p < n; p++) begin
        int h, l;
        h = ($urandom_range(0, 99) < 15) ? $urandom_range(1, 2) : $urandom_range(3, 35);
        l = (p == n - 1) ? $urandom_range(30, 45) : $urandom_range(1, 29);
        add(h, l);
      end
    end
    run_seq();
    repeat (5) @(negedge clk);

    vectors++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL event_count: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      $display("letter %0d: cyc=%0d %s code=%b len=%0d", i, obs[i].cyc,
               obs[i].is_err ? "err" : "valid", obs[i].code, obs[i].len);
      if (obs[i].cyc !== exp_q[i].cyc || obs[i].is_err !== exp_q[i].is_err ||
          obs[i].code !== exp_q[i].code || obs[i].len !== exp_q[i].len) begin
        errors++;
        $display("FAIL letter_%0d: got cyc=%0d err=%b code=%b len=%0d, expected cyc=%0d err=%b code=%b len=%0d",
                 i, obs[i].cyc, obs[i].is_err, obs[i].code, obs[i].len,
                 exp_q[i].cyc, exp_q[i].is_err, exp_q[i].code, exp_q[i].len);
      end
    end
  endtask

  task automatic test_clear();
    obs.delete(); exp_q.delete();
    @(negedge clk);
    // Three dots, then clear while waiting in the gap
    add(10, 10); add(10, 10);
    run_seq();
    key_in = 1'b1; repeat (10) @(negedge clk);
    key_in = 1'b0; repeat (10) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_gap: got %b, expected 1", busy);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_sym.delete(); m_ovf = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_clear: got %b, expected 0", busy);
    end
    repeat (40) @(negedge clk);
    // Clear while the key is held: the held press must not count
    key_in = 1'b1; repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (20) @(negedge clk);
    key_in = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (obs.size() !== 0) begin
      errors++;
      $display("FAIL clear_no_event: got %0d events, expected 0", obs.size());
    end
    vectors++;
    if (code !== m_code || len !== m_len) begin
      errors++;
      $display("FAIL clear_keeps_code: got code=%b len=%0d, expected code=%b len=%0d", code, len, m_code, m_len);
    end
    $display("clear: code=%b len=%0d busy=%b", code, len, busy);
    add(20, 40);
    run_seq();
    vectors++;
    if (obs.size() !== 1 || exp_q.size() !== 1) begin
      errors++;
      $display("FAIL clear_then_letter: got %0d events, expected 1", obs.size());
    end else begin
      vectors++;
      $display("letter after clear: cyc=%0d code=%b len=%0d", obs[0].cyc, obs[0].code, obs[0].len);
      if (obs[0].cyc !== exp_q[0].cyc || obs[0].is_err !== exp_q[0].is_err ||
          obs[0].code !== exp_q[0].code || obs[0].len !== exp_q[0].len) begin
        errors++;
        $display("FAIL clear_letter_value: got cyc=%0d code=%b len=%0d, expected cyc=%0d code=%b len=%0d",
                 obs[0].cyc, obs[0].code, obs[0].len, exp_q[0].cyc, exp_q[0].code, exp_q[0].len);
      end
    end
  endtask

  task automatic test_rst_mid_press();
    bit busy_seen;
    obs.delete(); exp_q.delete();
    @(negedge clk);
    add(10, 10); add(30, 40);
    run_seq();
    key_in = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({code, len, code_valid, err, busy} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got code=%b len=%0d cv=%b err=%b busy=%b, expected all 0",
               code, len, code_valid, err, busy);
    end
    m_sym.delete(); m_ovf = 1'b0; m_code = '0; m_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Key still held after reset release: must stay idle
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    key_in = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL held_key_after_reset: busy went high, expected 0");
    end
    add(20, 40);
    run_seq();
    vectors++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL reset_event_count: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      $display("letter around reset %0d: cyc=%0d code=%b len=%0d", i, obs[i].cyc, obs[i].code, obs[i].len);
      if (obs[i].cyc !== exp_q[i].cyc || obs[i].is_err !== exp_q[i].is_err ||
          obs[i].code !== exp_q[i].code || obs[i].len !== exp_q[i].len) begin
        errors++;
        $display("FAIL reset_letter_%0d: got cyc=%0d code=%b len=%0d, expected cyc=%0d code=%b len=%0d",
                 i, obs[i].cyc, obs[i].code, obs[i].len, exp_q[i].cyc, exp_q[i].code, exp_q[i].len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_letters();
    test_clear();
    test_rst_mid_press();
    vectors++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL valid_err_exclusive: got %0d overlapping cycles, expected 0", both_hi);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
